// File: rtl/dscmd_arbiter_pkg.sv
// Shared types and constants for the downstream command arbiter.
package dscmd_arbiter_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SRC_W  = 2;
  localparam int unsigned GAP_W  = 4;

  localparam logic [SRC_W-1:0] SRC_MAIN = 2'd0;
  localparam logic [SRC_W-1:0] SRC_ALT  = 2'd1;
  localparam logic [SRC_W-1:0] SRC_LCL  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              resprqst;
  } cmd_t;

  // Round-robin successor: MAIN -> ALT -> LOCAL -> MAIN.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] src);
    case (src)
      SRC_MAIN: return SRC_ALT;
      SRC_ALT:  return SRC_LCL;
      default:  return SRC_MAIN;
    endcase
  endfunction

endpackage

// File: rtl/dscmd_arbiter_if.sv
// Bus bundle between unpacker, local requester, arbiter and command consumer.
interface dscmd_arbiter_if
  import dscmd_arbiter_pkg::*;
#(
  parameter int unsigned OVR_W = 8
);

  logic [ADDR_W-1:0] ds_cmd_addr;
  logic [DATA_W-1:0] ds_cmd_data;
  logic              ds_cmd_resprqst;
  logic              ds_cmd_is_alt;
  logic              ds_cmd_cnt;

  logic              lcl_valid;
  logic              lcl_ready;
  logic [ADDR_W-1:0] lcl_addr;
  logic [DATA_W-1:0] lcl_data;
  logic              lcl_resprqst;

  logic              cmd_busy;
  logic              cmd_rqst;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_resprqst;
  logic [SRC_W-1:0]  cmd_src;
  logic              resp_cnt;

  logic [OVR_W-1:0]  ovr_main;
  logic [OVR_W-1:0]  ovr_alt;

  // Arbiter side.
  modport slave (
    input  ds_cmd_addr, ds_cmd_data, ds_cmd_resprqst, ds_cmd_is_alt, ds_cmd_cnt,
    input  lcl_valid, lcl_addr, lcl_data, lcl_resprqst,
    input  cmd_busy,
    output lcl_ready,
    output cmd_rqst, cmd_addr, cmd_data, cmd_resprqst, cmd_src, resp_cnt,
    output ovr_main, ovr_alt
  );

  // Environment side (unpacker, local requester, consumer).
  modport master (
    output ds_cmd_addr, ds_cmd_data, ds_cmd_resprqst, ds_cmd_is_alt, ds_cmd_cnt,
    output lcl_valid, lcl_addr, lcl_data, lcl_resprqst,
    output cmd_busy,
    input  lcl_ready,
    input  cmd_rqst, cmd_addr, cmd_data, cmd_resprqst, cmd_src, resp_cnt,
    input  ovr_main, ovr_alt
  );

endinterface

// File: rtl/dscmd_arbiter_cmd_slot.sv
// cmd_slot: one captured unpacker command with pending flag and saturating overrun count.
module dscmd_arbiter_cmd_slot
  import dscmd_arbiter_pkg::*;
#(
  parameter int unsigned OVR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             capture,
  input  cmd_t             cmd_in,
  input  logic             grant,
  output cmd_t             cmd,
  output logic             pend,
  output logic [OVR_W-1:0] ovr
);

  // Capture wins over grant; an overwrite of an ungranted pending command is an overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd  <= '0;
      pend <= 1'b0;
      ovr  <= '0;
    end else if (capture) begin
      cmd  <= cmd_in;
      pend <= 1'b1;
      if (pend && !grant && (ovr != '1)) begin
        ovr <= ovr + OVR_W'(1);
      end
    end else if (grant) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/dscmd_arbiter.sv
// Round-robin arbiter merging main/alt unpacker commands and a local requester
// into one paced command strobe stream.
module dscmd_arbiter
  import dscmd_arbiter_pkg::*;
#(
  parameter int unsigned GAP   = 2,
  parameter int unsigned OVR_W = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dscmd_arbiter_if.slave bus
);

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_cnt;
  logic [SRC_W-1:0] last_src;

  logic             cmd_rqst_q;
  logic             lcl_ready_q;
  logic             resp_cnt_q;
  cmd_t             cmd_q;
  logic [SRC_W-1:0] cmd_src_q;

  logic             new_cmd;
  logic             cap_main;
  logic             cap_alt;
  cmd_t             ds_cmd;
  cmd_t             lcl_cmd;
  cmd_t             main_cmd;
  cmd_t             alt_cmd;
  cmd_t             win_cmd;
  logic             main_pend;
  logic             alt_pend;

  logic             found;
  logic [SRC_W-1:0] winner;
  logic [SRC_W-1:0] cand;
  logic             cand_req;
  logic             grant_ok;
  logic             grant_main;
  logic             grant_alt;

  // Toggle-based new-command detect and slot steering.
  always_comb begin
    new_cmd  = bus.ds_cmd_cnt != last_cnt;
    cap_main = new_cmd && !bus.ds_cmd_is_alt;
    cap_alt  = new_cmd && bus.ds_cmd_is_alt;
    ds_cmd   = '{addr: bus.ds_cmd_addr, data: bus.ds_cmd_data, resprqst: bus.ds_cmd_resprqst};
    lcl_cmd  = '{addr: bus.lcl_addr, data: bus.lcl_data, resprqst: bus.lcl_resprqst};
  end

  dscmd_arbiter_cmd_slot #(.OVR_W(OVR_W)) u_main_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (cap_main),
    .cmd_in  (ds_cmd),
    .grant   (grant_main),
    .cmd     (main_cmd),
    .pend    (main_pend),
    .ovr     (bus.ovr_main)
  );

  dscmd_arbiter_cmd_slot #(.OVR_W(OVR_W)) u_alt_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (cap_alt),
    .cmd_in  (ds_cmd),
    .grant   (grant_alt),
    .cmd     (alt_cmd),
    .pend    (alt_pend),
    .ovr     (bus.ovr_alt)
  );

  // Round-robin search starting after the last granted source.
  always_comb begin
    found    = 1'b0;
    winner   = SRC_MAIN;
    cand     = next_src(last_src);
    cand_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      case (cand)
        SRC_MAIN: cand_req = main_pend;
        SRC_ALT:  cand_req = alt_pend;
        default:  cand_req = bus.lcl_valid;
      endcase
      if (!found && cand_req) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = next_src(cand);
    end
    case (winner)
      SRC_MAIN: win_cmd = main_cmd;
      SRC_ALT:  win_cmd = alt_cmd;
      default:  win_cmd = lcl_cmd;
    endcase
    grant_ok   = (state == ST_IDLE) && !bus.cmd_busy && found;
    grant_main = grant_ok && (winner == SRC_MAIN);
    grant_alt  = grant_ok && (winner == SRC_ALT);
  end

  // Grant / issue / pacing FSM with registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      gap_cnt     <= '0;
      last_cnt    <= 1'b0;
      last_src    <= SRC_LCL;
      cmd_rqst_q  <= 1'b0;
      lcl_ready_q <= 1'b0;
      resp_cnt_q  <= 1'b0;
      cmd_q       <= '0;
      cmd_src_q   <= SRC_MAIN;
    end else begin
      last_cnt    <= bus.ds_cmd_cnt;
      cmd_rqst_q  <= 1'b0;
      lcl_ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ok) begin
            cmd_q       <= win_cmd;
            cmd_src_q   <= winner;
            last_src    <= winner;
            lcl_ready_q <= (winner == SRC_LCL);
            cmd_rqst_q  <= 1'b1;
            if (win_cmd.resprqst) begin
              resp_cnt_q <= ~resp_cnt_q;
            end
            state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (GAP != 0) begin
            gap_cnt <= GAP_W'(GAP - 1);
            state   <= ST_GAP;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Drive registered outputs onto the bus.
  always_comb begin
    bus.cmd_rqst     = cmd_rqst_q;
    bus.lcl_ready    = lcl_ready_q;
    bus.cmd_addr     = cmd_q.addr;
    bus.cmd_data     = cmd_q.data;
    bus.cmd_resprqst = cmd_q.resprqst;
    bus.cmd_src      = cmd_src_q;
    bus.resp_cnt     = resp_cnt_q;
  end

endmodule

// File: tb/tb_dscmd_arbiter.sv
// Directed scoreboard bench for dscmd_arbiter.
module tb_dscmd_arbiter;
  import dscmd_arbiter_pkg::*;

  typedef struct packed {
    logic [1:0]  src;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        rsp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dscmd_arbiter_if #(.OVR_W(8)) bus ();

  dscmd_arbiter #(.GAP(2), .OVR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   nvec = 0;
  int   nerr = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   strobe_hist[$];
  int   lcl_ready_cnt = 0;
  int   lcl_handled = 0;
  logic exp_resp = 1'b0;
  exp_t mon_e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each strobe.
  always @(negedge clk) begin
    if (!rst_n) exp_resp = 1'b0;
    if (bus.lcl_ready === 1'b1) begin
      lcl_ready_cnt++;
      check("lcl_ready_needs_valid", bus.lcl_valid, 1);
    end
    if (bus.cmd_rqst === 1'b1) begin
      strobe_hist.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("spurious_strobe", bus.cmd_rqst, 0);
      end else begin
        mon_e = exp_q.pop_front();
        exp_resp = exp_resp ^ mon_e.rsp;
        check("cmd_fields", {bus.cmd_src, bus.cmd_addr, bus.cmd_data, bus.cmd_resprqst}, mon_e);
        check("resp_cnt", bus.resp_cnt, exp_resp);
      end
    end
  end

  // One clock; the local requester drops valid once ready has been seen.
  task automatic step();
    @(posedge clk);
    #1;
    if (lcl_ready_cnt != lcl_handled) begin
      lcl_handled   = lcl_ready_cnt;
      bus.lcl_valid = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_exp(input logic [1:0] src, input logic [5:0] a, input logic [31:0] d, input logic r);
    exp_t e;
    e = '{src: src, addr: a, data: d, rsp: r};
    exp_q.push_back(e);
  endtask

  task automatic ds_toggle(input logic alt, input logic [5:0] a, input logic [31:0] d, input logic r);
    bus.ds_cmd_is_alt   = alt;
    bus.ds_cmd_addr     = a;
    bus.ds_cmd_data     = d;
    bus.ds_cmd_resprqst = r;
    bus.ds_cmd_cnt      = ~bus.ds_cmd_cnt;
    step();
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
    check(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {bus.cmd_rqst, bus.lcl_ready, bus.cmd_resprqst, bus.resp_cnt, bus.cmd_src}, 0);
    check({tag, "_addr"}, bus.cmd_addr, 0);
    check({tag, "_data"}, bus.cmd_data, 0);
    check({tag, "_ovr"}, {bus.ovr_main, bus.ovr_alt}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int lr0;

    rst_n               = 1'b0;
    bus.ds_cmd_addr     = '0;
    bus.ds_cmd_data     = '0;
    bus.ds_cmd_resprqst = 1'b0;
    bus.ds_cmd_is_alt   = 1'b0;
    bus.ds_cmd_cnt      = 1'b0;
    bus.lcl_valid       = 1'b0;
    bus.lcl_addr        = '0;
    bus.lcl_data        = '0;
    bus.lcl_resprqst    = 1'b0;
    bus.cmd_busy        = 1'b0;
    settle(2);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    settle(2);

    // Single main command: 2-cycle latency, no response.
    base = strobe_hist.size();
    t0   = cyc;
    push_exp(SRC_MAIN, 6'h09, 32'h12345678, 1'b0);
    ds_toggle(1'b0, 6'h09, 32'h12345678, 1'b0);
    drain("t1_drain", 20);
    settle(5);
    if (strobe_hist.size() > base) check("t1_latency", strobe_hist[base] - t0, 2);
    check("t1_resp_cnt", bus.resp_cnt, 0);

    // Local request with response.
    lr0              = lcl_ready_cnt;
    bus.lcl_addr     = 6'h2A;
    bus.lcl_data     = 32'hCAFEF00D;
    bus.lcl_resprqst = 1'b1;
    bus.lcl_valid    = 1'b1;
    push_exp(SRC_LCL, 6'h2A, 32'hCAFEF00D, 1'b1);
    drain("t4_drain", 20);
    settle(5);
    check("t4_lcl_ready_pulses", lcl_ready_cnt - lr0, 1);
    check("t4_lcl_valid_dropped", bus.lcl_valid, 0);
    check("t4_resp_cnt", bus.resp_cnt, 1);

    // Contention: all three pending together, issued MAIN, ALT, LOCAL 4 cycles apart.
    bus.cmd_busy = 1'b1;
    push_exp(SRC_MAIN, 6'h01, 32'h11111111, 1'b1);
    ds_toggle(1'b0, 6'h01, 32'h11111111, 1'b1);
    bus.lcl_addr     = 6'h03;
    bus.lcl_data     = 32'h33333333;
    bus.lcl_resprqst = 1'b0;
    bus.lcl_valid    = 1'b1;
    push_exp(SRC_ALT, 6'h02, 32'h22222222, 1'b0);
    ds_toggle(1'b1, 6'h02, 32'h22222222, 1'b0);
    push_exp(SRC_LCL, 6'h03, 32'h33333333, 1'b0);
    settle(2);
    base         = strobe_hist.size();
    check("t2_held_while_busy", base, strobe_hist.size());
    bus.cmd_busy = 1'b0;
    drain("t2_drain", 40);
    settle(5);
    if (strobe_hist.size() >= base + 3) begin
      check("t2_spacing_main_alt", strobe_hist[base+1] - strobe_hist[base], 4);
      check("t2_spacing_alt_lcl", strobe_hist[base+2] - strobe_hist[base+1], 4);
    end

    // Overrun while busy: only the second command issues.
    bus.cmd_busy = 1'b1;
    ds_toggle(1'b0, 6'h05, 32'hAAAA0001, 1'b0);
    push_exp(SRC_MAIN, 6'h06, 32'hBBBB0002, 1'b1);
    ds_toggle(1'b0, 6'h06, 32'hBBBB0002, 1'b1);
    step();
    check("t3_ovr_main", bus.ovr_main, 1);
    bus.cmd_busy = 1'b0;
    drain("t3_drain", 20);
    settle(5);
    check("t3_ovr_main_after", bus.ovr_main, 1);
    check("t3_ovr_alt", bus.ovr_alt, 0);

    // Saturation: 301 alt captures while busy = 300 overruns.
    bus.cmd_busy = 1'b1;
    for (int i = 1; i <= 301; i++) begin
      if (i == 301) push_exp(SRC_ALT, 6'h3F, 32'(i), 1'b0);
      ds_toggle(1'b1, 6'h3F, 32'(i), 1'b0);
      if (i == 255) check("t6_ovr_254", bus.ovr_alt, 254);
      if (i == 256) check("t6_ovr_255", bus.ovr_alt, 255);
    end
    check("t6_ovr_sat", bus.ovr_alt, 255);
    bus.cmd_busy = 1'b0;
    drain("t6_drain", 20);
    settle(5);
    check("t6_ovr_hold", bus.ovr_alt, 255);

    // Reset mid-GAP, then MAIN must win first despite MAIN being last granted.
    base = strobe_hist.size();
    push_exp(SRC_MAIN, 6'h11, 32'h5A5A5A5A, 1'b1);
    ds_toggle(1'b0, 6'h11, 32'h5A5A5A5A, 1'b1);
    for (int i = 0; i < 20 && strobe_hist.size() == base; i++) step();
    check("t5_pre_strobe", strobe_hist.size() - base, 1);
    step();
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset_immediate");
    bus.ds_cmd_cnt = 1'b0;
    settle(2);
    check_reset_outputs("t5_reset_held");
    rst_n = 1'b1;
    settle(2);
    base         = strobe_hist.size();
    bus.cmd_busy = 1'b1;
    ds_toggle(1'b1, 6'h21, 32'h21212121, 1'b0);
    ds_toggle(1'b0, 6'h12, 32'h12121212, 1'b1);
    bus.lcl_addr     = 6'h33;
    bus.lcl_data     = 32'h33333333;
    bus.lcl_resprqst = 1'b0;
    bus.lcl_valid    = 1'b1;
    step();
    check("t5_no_strobe_after_reset", strobe_hist.size() - base, 0);
    push_exp(SRC_MAIN, 6'h12, 32'h12121212, 1'b1);
    push_exp(SRC_ALT, 6'h21, 32'h21212121, 1'b0);
    push_exp(SRC_LCL, 6'h33, 32'h33333333, 1'b0);
    bus.cmd_busy = 1'b0;
    drain("t5_drain", 40);
    settle(5);
    check("t5_strobes", strobe_hist.size() - base, 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
